// File: rtl/uart_pkg.sv
// Shared types and frame-timing helper for the UART transmit path.
// No logic; consumed at elaboration by the arbiter and its submodules.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // One start, one stop and one guard bit around the data bits.
    function automatic int frame_cycles(input int clock, input int baud, input int data);
        return (clock / baud) * (data + 3);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select with packet-lock override; one-hot output.
// Latency: purely combinational.
// Backpressure: none; a locked owner that is not requesting yields an all-zero grant.
module rr_arbiter import uart_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    mask_base,
    input  logic [N_REQ-1:0] lock_id,
    output logic [N_REQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (|lock_id) begin
            gnt = lock_id & req;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (!found && req[(int'(mask_base) + k) % N_REQ]) begin
                    gnt[(int'(mask_base) + k) % N_REQ] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte requesters, keeping packets contiguous.
// Latency: new_data pulses 1 cycle after the transfer edge; pulses at least FRAME_CYC+2 apart.
// Backpressure: req_ready only in IDLE, one-hot; requesters hold req_valid until accepted.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int DATA  = 8,
    parameter int CLOCK = 50000000,
    parameter int BAUD  = 9600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DATA-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  new_data,
    output logic [DATA-1:0]       data_in,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy
);

    localparam int FRAME_CYC = frame_cycles(CLOCK, BAUD, DATA);
    localparam int CW        = $clog2(FRAME_CYC);
    localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              lock;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     win_idx;
    logic [N_REQ-1:0]  win;
    logic [N_REQ-1:0]  lock_id;
    logic              xfer;

    // grant stays on the owner while locked, so it doubles as the lock target.
    assign lock_id = lock ? grant : '0;
    assign busy    = (state != IDLE);

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req       (req_valid),
        .mask_base (last_grant),
        .lock_id   (lock_id),
        .gnt       (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        new_data  = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (rst) req_ready = win;
                if (|win) begin
                    xfer      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                new_data  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            lock       <= 1'b0;
            last_grant <= IW'(N_REQ - 1);
            data_in    <= '0;
            grant      <= '0;
        end else begin
            if (xfer) begin
                data_in    <= req_data[win_idx*DATA +: DATA];
                grant      <= win;
                last_grant <= win_idx;
                lock       <= ~req_last[win_idx];
            end
            if (state == ISSUE) begin
                cnt <= CW'(FRAME_CYC - 1);
            end else if (state == HOLD) begin
                if (cnt != '0)  cnt   <= cnt - 1'b1;
                else if (!lock) grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a countdown/ownership reference model.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int D     = 8;
    localparam int CLOCK = 1000;
    localparam int BAUD  = 100;
    localparam int FRAME = (CLOCK / BAUD) * (D + 3);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*D-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic             new_data;
    logic [D-1:0]     data_in;
    logic [N-1:0]     grant;
    logic             busy;

    uart_tx_arbiter #(.N_REQ(N), .DATA(D), .CLOCK(CLOCK), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .new_data  (new_data),
        .data_in   (data_in),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: busy_left counts cycles until the transmitter is free again.
    int          busy_left = 0;
    bit          lock_m    = 1'b0;
    int          last_g    = N - 1;
    int          own       = -1;
    logic [D-1:0] exp_data = '0;
    int          vprob     = 50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] one;
        one = 1;
        if (busy_left != 0 || !rst) return '0;
        if (lock_m) return req_valid[own] ? (one << own) : '0;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(last_g + k) % N]) return one << ((last_g + k) % N);
        end
        return '0;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] one;
        one = 1;
        return (own < 0) ? '0 : (one << own);
    endfunction

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = ($urandom_range(0, 99) < vprob);
            req_data[i*D +: D]  = D'($urandom);
            req_last[i]         = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic model_reset();
        busy_left = 0;
        lock_m    = 1'b0;
        last_g    = N - 1;
        own       = -1;
        exp_data  = '0;
    endtask

    // One clock: compare at negedge, advance model at posedge, re-drive inputs.
    task automatic step();
        logic [N-1:0] r;
        int           idx;
        @(negedge clk);
        r = exp_ready();
        check("req_ready", 32'(req_ready), 32'(r));
        check("busy", 32'(busy), 32'(busy_left > 0));
        check("new_data", 32'(new_data), 32'(busy_left == FRAME + 1));
        check("grant", 32'(grant), 32'(exp_grant()));
        check("data_in", 32'(data_in), 32'(exp_data));
        @(posedge clk);
        if (r != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (r[i]) idx = i;
            exp_data  = req_data[idx*D +: D];
            own       = idx;
            last_g    = idx;
            lock_m    = !req_last[idx];
            busy_left = FRAME + 1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0 && !lock_m) own = -1;
        end
        #1;
        drive_random();
    endtask

    initial begin
        bit reached;
        model_reset();
        repeat (3) step();
        #3 rst = 1'b1;

        // Everyone requesting straight out of reset: requester 0 must win.
        req_valid = '1;
        req_last  = '1;
        step();

        repeat (6000) step();

        // Reset 40 cycles into HOLD must clear everything without a clock edge.
        reached = 1'b0;
        vprob   = 80;
        for (int i = 0; i < 3000 && !reached; i++) begin
            step();
            if (busy_left == FRAME - 40) reached = 1'b1;
        end
        check("reach_hold40", 32'(reached), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_new_data", 32'(new_data), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_data_in", 32'(data_in), 32'd0);
        model_reset();
        step();
        #3 rst = 1'b1;
        req_valid = '1;
        step();

        vprob = 40;
        repeat (1500) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters sharing one UART transmitter.
REQ-002 Parameter DATA, default 8: data bits per UART frame.
REQ-003 Parameter CLOCK, default 50000000: clk frequency in Hz.
REQ-004 Parameter BAUD, default 9600: UART bit rate.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  N_REQ  per-requester byte-available flag.
REQ-008 req_data  input  N_REQ*DATA  per-requester byte; requester i occupies bits [i*DATA +: DATA].
REQ-009 req_last  input  N_REQ  per-requester flag: byte is the final byte of its packet.
REQ-010 req_ready  output  N_REQ  one-hot accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both high at a posedge.
REQ-011 new_data  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 data_in  output  DATA  byte to the UART transmitter, stable from the new_data pulse until the frame completes.
REQ-013 grant  output  N_REQ  one-hot owner of the transmitter; all-zero when unowned.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The arbiter SHALL derive BIT_CYC = CLOCK/BAUD and FRAME_CYC = BIT_CYC*(DATA+3); this is one start bit, one stop bit and one guard bit.
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and HOLD.
REQ-017 IDLE SHALL select the winner combinationally, with req_ready[winner] = 1 and all other req_ready bits 0.
- The winner is the locked requester when lock = 1.
- Otherwise the winner is the first requester with req_valid high, searching round-robin from (last_grant+1) mod N_REQ.
REQ-018 IDLE SHALL hold all req_ready bits at 0 when no eligible requester is valid.
REQ-019 On a transfer, the arbiter SHALL register req_data into data_in, set grant and last_grant to the winner, and go to ISSUE.
- A transfer with req_last = 0 SHALL set lock = 1.
- A transfer with req_last = 1 SHALL set lock = 0.
REQ-020 ISSUE SHALL drive new_data = 1 for exactly one cycle, load the frame counter with FRAME_CYC-1, and go to HOLD.
REQ-021 HOLD SHALL decrement the frame counter each cycle and go to IDLE on the cycle it reads 0; HOLD therefore lasts exactly FRAME_CYC cycles.
REQ-022 The frame counter width SHALL be $clog2(FRAME_CYC), and the counter SHALL NOT wrap below 0.
REQ-023 Latency SHALL be 1 cycle from the transfer edge to the new_data pulse; the minimum spacing between new_data pulses SHALL be FRAME_CYC+2 cycles.
REQ-024 While lock = 1, other requesters SHALL be ignored even if the locked requester drops req_valid; the arbiter waits in IDLE indefinitely.
REQ-025 grant SHALL remain asserted through ISSUE and HOLD.
- grant SHALL remain asserted in IDLE while lock = 1.
- grant SHALL clear on entry to IDLE when lock = 0.
REQ-026 Changes to req_data or req_last after the transfer edge SHALL NOT affect data_in or lock.
REQ-027 Requester index 0 is lowest; round-robin wrap SHALL go from N_REQ-1 to 0.

Reset
REQ-028 Asserting rst low at any time, including mid-frame, SHALL immediately force the following: state = IDLE, frame counter = 0, lock = 0, last_grant = N_REQ-1 (so requester 0 wins first), data_in = 0, grant = 0, new_data = 0, busy = 0, req_ready = 0.
REQ-029 After rst deasserts, the first transfer SHALL be possible on the first posedge.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state enum (IDLE, ISSUE, HOLD) and a function computing FRAME_CYC from CLOCK, BAUD and DATA.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req, mask_base and lock_id, and a one-hot output; it SHALL be purely combinational.
REQ-032 The UART transmitter itself SHALL NOT be instantiated inside this block; new_data and data_in connect to it at the parent level.

Verification (CLOCK=1000, BAUD=100, DATA=8: BIT_CYC=10, FRAME_CYC=110)
REQ-033 Single requester: req 0 sends 0xA5 with last=1 -> req_ready[0] pulses once, new_data pulses the next cycle with data_in=0xA5, busy stays high 111 cycles, and no second ready occurs before then.
REQ-034 All four requesters valid with last=1, bytes 0x10..0x13 -> new_data carries 0x10, 0x11, 0x12, 0x13, then 0x10 again, with pulses exactly 112 cycles apart.
REQ-035 Packet lock: req 1 sends 0x01, 0x02, 0x03 (last on 0x03) while req 2 is valid with 0x55 -> 0x55 is issued only after 0x03, and grant[1] stays high throughout the packet.
REQ-036 Stalled lock: req 0 sends last=0 then drops valid while req 3 is valid -> no ready pulse for 500 cycles; when req 0 returns with last=1, its byte goes first, then req 3's byte.
REQ-037 Reset mid-frame: rst pulled low 40 cycles into HOLD -> busy, grant and new_data go to 0 asynchronously; after release, req 0 wins first.
